seq_mult32: RTL and testbench



---
 rtl/seq_mult32.sv | 168 ++++++++++++++++
 tb/tb_seq_mult32.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult32.sv
// Iterative 32x32 -> 64-bit shift-and-add multiplier (33-cycle fixed latency).
// A single Kogge-Stone adder forms every partial sum; the carry is kept by the 65-bit shift.

module koggestone32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cIn,
    output logic [31:0] s,
    output logic        cOut
);

    logic [31:0] halfSum;
    logic [31:0] gen;
    logic [31:0] prop;
    logic [31:0] genNext;
    logic [31:0] propNext;

    // Five prefix levels (span 1, 2, 4, 8, 16); gen[i] ends up as the carry out of bit i.
    always_comb begin
        // NOTE: blocking assignments here model a chain of combinational stages;
        // registers elsewhere use non-blocking so every flop samples pre-edge values.
        halfSum  = a ^ b;
        gen      = a & b;
        prop     = halfSum;
        gen[0]   = gen[0] | (prop[0] & cIn);
        genNext  = gen;
        propNext = prop;
        for (int lvl = 0; lvl < 5; lvl++) begin
            genNext  = gen;
            propNext = prop;
            for (int i = (1 << lvl); i < 32; i++) begin
                genNext[i]  = gen[i] | (prop[i] & gen[i - (1 << lvl)]);
                propNext[i] = prop[i] & prop[i - (1 << lvl)];
            end
            gen  = genNext;
            prop = propNext;
        end
        s    = halfSum ^ {gen[30:0], cIn};
        cOut = gen[31];
    end

endmodule

module seq_mult32 #(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } stateT;

    stateT       state;
    stateT       nextState;

    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mcand;
    logic [4:0]  count;
    logic        neg;

    logic        loadOps;
    logic        stepEn;
    logic        finish;

    logic        signedMode;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [31:0] addend;
    logic [31:0] sum;
    logic        carry;

    // Magnitudes are plain unsigned 32-bit values, so 0x80000000 maps to 2^31.
    assign signedMode = SIGNED_EN & sgn;
    assign aMag       = (signedMode && a[31]) ? (~a + 32'd1) : a;
    assign bMag       = (signedMode && b[31]) ? (~b + 32'd1) : b;
    assign addend     = lo[0] ? mcand : 32'd0;

    koggestone32bit adder (
        .a    (hi),
        .b    (addend),
        .cIn  (1'b0),
        .s    (sum),
        .cOut (carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred when a branch leaves the value alone.
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (count == 5'd31) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        loadOps = 1'b0;
        stepEn  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: loadOps = start;
            RUN: begin
                busy   = 1'b1;
                stepEn = 1'b1;
            end
            FIX: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: every datapath register is cleared on reset so an aborted
        // operation leaves no stale partial product behind.
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            count   <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= finish;
            if (loadOps) begin
                neg   <= signedMode & (a[31] ^ b[31]);
                mcand <= aMag;
                lo    <= bMag;
                hi    <= '0;
                count <= '0;
            end
            if (stepEn) begin
                hi    <= {carry, sum[31:1]};
                lo    <= {sum[0], lo[31:1]};
                count <= count + 5'd1;
            end
            if (finish) begin
                product <= neg ? (~{hi, lo} + 64'd1) : {hi, lo};
            end
        end
    end

endmodule

// File: tb/tb_seq_mult32.sv
// Scoreboard bench for seq_mult32: stimulus pushes expected products, monitors pop on done.
// A second instance with SIGNED_EN=0 confirms sgn is ignored there.

module tb_seq_mult32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        startU;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        busyU;
    logic        doneU;
    logic [63:0] productU;

    int          passCnt = 0;
    int          totalCnt = 0;
    int          cycleCnt = 0;
    int          acceptCycle = 0;
    int          busyCnt = 0;
    logic [63:0] expQ[$];
    logic [63:0] expQU[$];
    logic [63:0] expV;
    logic [63:0] expVU;

    seq_mult32 #(.SIGNED_EN(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    seq_mult32 #(.SIGNED_EN(1'b0)) dutU (
        .clk     (clk),
        .reset   (reset),
        .start   (startU),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .busy    (busyU),
        .done    (doneU),
        .product (productU)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Signed-capable instance monitor: product, busy length, exclusivity of busy/done.
    always @(negedge clk) begin
        if (reset) begin
            busyCnt = 0;
        end else begin
            if (busy) busyCnt++;
            if (done) begin
                check("busy low during done", 64'(busy), 64'd0);
                if (expQ.size() == 0) begin
                    check("spurious done", 64'(done), 64'd0);
                end else begin
                    expV = expQ.pop_front();
                    check("product", product, expV);
                    check("busy cycles", 64'(busyCnt), 64'd33);
                end
                busyCnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && doneU) begin
            if (expQU.size() == 0) begin
                check("spurious doneU", 64'(doneU), 64'd0);
            end else begin
                expVU = expQU.pop_front();
                check("productU", productU, expVU);
            end
        end
    end

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input logic [63:0] ev, input bit useU);
        a   = av;
        b   = bv;
        sgn = sv;
        if (useU) begin
            startU = 1'b1;
            expQU.push_back(ev);
        end else begin
            start = 1'b1;
            expQ.push_back(ev);
        end
        @(posedge clk);
        #1;
        acceptCycle = cycleCnt;
        start  = 1'b0;
        startU = 1'b0;
    endtask

    task automatic waitDone(input bit useU, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (useU ? doneU : done) seen = 1'b1;
        end
        check(name, seen ? 64'(cycleCnt - acceptCycle) : 64'hFFFF_FFFF_FFFF_FFFF, 64'd33);
    endtask

    logic [31:0] va[7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                           32'h00000000, 32'h00000007, 32'h80000000};
    logic [31:0] vb[7] = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'h80000000,
                           32'hFFFFFFFB, 32'hFFFFFFFF, 32'h00000002};
    logic        vs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] vp[7] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1, 64'd1,
                           64'h40000000_00000000, 64'd0, 64'hFFFFFFFF_FFFFFFF9,
                           64'h00000001_00000000};

    initial begin
        int doneSeen;
        reset  = 1'b1;
        start  = 1'b0;
        startU = 1'b0;
        sgn    = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", product, 64'd0);
        check("reset busyU", 64'(busyU), 64'd0);
        check("reset doneU", 64'(doneU), 64'd0);
        check("reset productU", productU, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 3*5 with a second start at N+5 that must be ignored
        issue(32'd3, 32'd5, 1'b0, 64'd15, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        a     = 32'd7;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(1'b0, "latency 3x5");

        // start in the done cycle is accepted
        issue(32'd7, 32'd7, 1'b0, 64'd49, 1'b0);
        waitDone(1'b0, "latency back-to-back");
        repeat (3) @(negedge clk);
        check("product held", product, 64'd49);
        check("idle busy", 64'(busy), 64'd0);
        check("idle done", 64'(done), 64'd0);

        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            issue(va[k], vb[k], vs[k], vp[k], 1'b0);
            waitDone(1'b0, $sformatf("latency vec%0d", k));
        end

        // abort mid-operation: reset sampled at edge N+10
        @(posedge clk);
        #1;
        a     = 32'd100;
        b     = 32'd100;
        sgn   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort product", product, 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        check("no done after abort", 64'(doneSeen), 64'd0);
        @(posedge clk);
        #1;
        issue(32'd2, 32'd2, 1'b0, 64'd4, 1'b0);
        waitDone(1'b0, "latency after abort");

        // SIGNED_EN=0 instance treats sgn=1 as unsigned
        @(posedge clk);
        #1;
        issue(32'hFFFFFFFF, 32'd2, 1'b1, 64'h00000001_FFFFFFFE, 1'b1);
        waitDone(1'b1, "latency unsigned-only");

        repeat (2) @(negedge clk);
        check("pending expected", 64'(expQ.size()), 64'd0);
        check("pending expectedU", 64'(expQU.size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
